// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and defaults for the pipelined adder and its result collector
package adder_pkg;
  localparam int ADDER_DATA_W = 64;
  localparam int ADDER_FIFO_DEPTH = 16;
  localparam int ADDER_FRAME_LEN = 8;
  localparam int ADDER_PTR_W = $clog2(ADDER_FIFO_DEPTH);
  localparam int ADDER_LVL_W = ADDER_PTR_W + 1;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adder_sync_fifo.sv
// adder_sync_fifo: synchronous FIFO (push_i/pop_i pre-qualified, dout_o = head word, level_o = stored words)
module adder_sync_fifo
  import adder_pkg::*;
#(
  parameter int DATA_W = ADDER_DATA_W,
  parameter int DEPTH  = ADDER_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      din_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_ptr_q] <= din_i;
  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
endmodule

// File: rtl/adder_result_collector.sv
// adder_result_collector: buffers adder results into a framed valid/ready stream with sticky overflow (optional drop_count via COLLECTOR_DROP_CNT_EN)
module adder_result_collector
  import adder_pkg::*;
#(
  parameter int DATA_W    = ADDER_DATA_W,
  parameter int DEPTH     = ADDER_FIFO_DEPTH,
  parameter int FRAME_LEN = ADDER_FRAME_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      din,
  input  logic                   din_tvalid,
  output logic [DATA_W-1:0]      m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  input  logic                   clr_overflow
`ifdef COLLECTOR_DROP_CNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);
  localparam int FW = cnt_w(FRAME_LEN);
  logic full, empty, pop, push, drop, is_last;
  logic ovf_q, ovf_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  assign pop     = m_tvalid & m_tready;
  assign push    = din_tvalid & (~full | pop);
  assign drop    = din_tvalid & full & ~pop;
  assign is_last = fcnt_q == FW'(FRAME_LEN - 1);
  adder_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (m_tdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fill_level)
  );
  always_comb begin
    ovf_d  = drop ? 1'b1 : clr_overflow ? 1'b0 : ovf_q;
    fcnt_d = pop ? (is_last ? '0 : fcnt_q + FW'(1)) : fcnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      fcnt_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      fcnt_q <= fcnt_d;
    end
  end
  assign m_tvalid = ~empty;
  assign m_tlast  = m_tvalid & is_last;
  assign overflow = ovf_q;
`ifdef COLLECTOR_DROP_CNT_EN
  logic [15:0] dcnt_q, dcnt_d;
  always_comb begin
    dcnt_d = drop ? (clr_overflow ? 16'd1 : (&dcnt_q ? dcnt_q : dcnt_q + 16'd1))
                  : (clr_overflow ? 16'd0 : dcnt_q);
  end
  always_ff @(posedge clk) begin
    if (rst) dcnt_q <= '0;
    else dcnt_q <= dcnt_d;
  end
  assign drop_count = dcnt_q;
`endif
endmodule

// File: tb/tb_adder_result_collector.sv
// tb_adder_result_collector: scoreboard bench for adder_result_collector
module tb_adder_result_collector;
  logic clk = 0, rst = 0, din_tvalid = 0, m_tready = 0, clr_overflow = 0;
  logic [63:0] din = '0;
  logic [63:0] m_tdata;
  logic m_tvalid, m_tlast, overflow;
  logic [4:0] fill_level;
`ifdef COLLECTOR_DROP_CNT_EN
  logic [15:0] drop_count;
`endif
  int total = 0, bad = 0;
  logic [63:0] sb [$];
  logic live = 0, movf = 0, stall_prev = 0, prev_l = 0;
  logic [63:0] prev_d = '0;
  int fcnt = 0, mdcnt = 0;

  always #5 clk = ~clk;

  adder_result_collector dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_tvalid   (din_tvalid),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef COLLECTOR_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic dv, input logic [63:0] d, input logic rdy, input logic clr);
    logic pop, full, acc, drop;
    rst = r; din_tvalid = dv; din = d; m_tready = rdy; clr_overflow = clr;
    #4;
    if (live) begin
      chk("valid", m_tvalid, sb.size() != 0);
      chk("fill", fill_level, sb.size());
      chk("overflow", overflow, movf);
`ifdef COLLECTOR_DROP_CNT_EN
      chk("drop_count", drop_count, mdcnt);
`endif
      if (sb.size() != 0) begin
        chk("data", m_tdata, sb[0]);
        chk("last", m_tlast, fcnt == 7);
      end else chk("last_idle", m_tlast, 0);
      if (stall_prev && m_tvalid) begin
        chk("hold_data", m_tdata, prev_d);
        chk("hold_last", m_tlast, prev_l);
      end
    end
    stall_prev = m_tvalid & ~rdy; prev_d = m_tdata; prev_l = m_tlast;
    if (r) begin
      sb.delete(); movf = 0; fcnt = 0; mdcnt = 0; stall_prev = 0; live = 1;
    end else begin
      pop  = sb.size() != 0 && rdy;
      full = sb.size() == 16;
      acc  = dv && (!full || pop);
      drop = dv && full && !pop;
      if (pop) begin
        void'(sb.pop_front());
        fcnt = fcnt == 7 ? 0 : fcnt + 1;
      end
      if (acc) sb.push_back(d);
      movf = drop ? 1'b1 : clr ? 1'b0 : movf;
      mdcnt = drop ? (clr ? 1 : (mdcnt == 65535 ? mdcnt : mdcnt + 1)) : (clr ? 0 : mdcnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // passthrough
    for (int i = 1; i <= 20; i++) step(0, 1, i, 1, 0);
    idle(3, 1);
    // mid-stream reset with partial frame and stored words
    for (int i = 0; i < 5; i++) step(0, 1, 64'h300 + i, i < 2, 0);
    step(1, 1, 64'h3FF, 1, 0);
    step(1, 0, 0, 1, 0);
    idle(1, 1);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_fill", fill_level, 0);
    // overflow
    for (int i = 0; i < 17; i++) step(0, 1, 64'hA0 + i, 0, 0);
    chk("ovf_fill16", fill_level, 16);
    chk("ovf_set", overflow, 1);
    idle(18, 1);
    step(0, 0, 0, 1, 1);
    chk("ovf_clr", overflow, 0);
    // full with simultaneous pop
    for (int i = 0; i < 16; i++) step(0, 1, 64'h100 + i, 0, 0);
    step(0, 1, 64'h55, 1, 0);
    chk("fullpop_fill", fill_level, 16);
    chk("fullpop_ovf", overflow, 0);
    idle(18, 1);
    // clear race
    for (int i = 0; i < 16; i++) step(0, 1, 64'h200 + i, 0, 0);
    step(0, 1, 64'h2FF, 0, 1);
    chk("race_ovf", overflow, 1);
`ifdef COLLECTOR_DROP_CNT_EN
    chk("race_dcnt", drop_count, 1);
`endif
    step(0, 0, 0, 0, 1);
    chk("clr_alone", overflow, 0);
    idle(18, 1);
    // random stall
    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    idle(20, 1);
    chk("drained", m_tvalid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
